// File: rtl/adder_arbiter_if.sv
// Bundle of request, operand, grant and result signals between the requester
// clients/result consumer and the shared adder arbiter.
//   req       : request bit per requester
//   a_in/b_in : packed operands, requester i at [i*size +: size]
//   c_in      : carry-in per requester
//   gnt       : one-hot grant pulse
//   busy      : arbiter is not idle
//   res_*     : result payload with valid/ready handshake
//   op_cnt    : completed-transaction counter
interface adder_arbiter_if #(
    parameter int unsigned size = 8,
    parameter int unsigned nreq = 4,
    parameter int unsigned idw  = 2
);
    logic [nreq-1:0]      req;
    logic [nreq*size-1:0] a_in;
    logic [nreq*size-1:0] b_in;
    logic [nreq-1:0]      c_in;
    logic [nreq-1:0]      gnt;
    logic                 busy;
    logic                 res_valid;
    logic                 res_ready;
    logic [size-1:0]      res_sum;
    logic                 res_cout;
    logic [idw-1:0]       res_id;
    logic [15:0]          op_cnt;

    // Client side: requesters and result consumer
    modport master (
        output req, a_in, b_in, c_in, res_ready,
        input  gnt, busy, res_valid, res_sum, res_cout, res_id, op_cnt
    );

    // Arbiter side
    modport slave (
        input  req, a_in, b_in, c_in, res_ready,
        output gnt, busy, res_valid, res_sum, res_cout, res_id, op_cnt
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder between nreq requesters.
// A winner is chosen in IDLE, its operands latched, the sum computed in CALC
// and held in HOLD until the consumer accepts it.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : adder_arbiter_if slave modport (requests, operands, grant, result)
module adder_arbiter #(
    parameter int unsigned size = 8,
    parameter int unsigned nreq = 4,
    parameter int unsigned idw  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);
    localparam int unsigned sw = size + 1;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t          state;
    logic [idw-1:0]  last;
    logic [idw-1:0]  win_id;
    logic [size-1:0] op_a;
    logic [size-1:0] op_b;
    logic            op_c;

    logic [idw-1:0]  pick_c;
    logic [idw-1:0]  idx_c;
    logic            found_c;
    logic [size-1:0] sel_a_c;
    logic [size-1:0] sel_b_c;
    logic            sel_c_c;

    // Winner search: first set req bit starting just after the last winner
    always_comb begin
        pick_c  = '0;
        idx_c   = '0;
        found_c = 1'b0;
        sel_a_c = '0;
        sel_b_c = '0;
        sel_c_c = 1'b0;
        for (int unsigned k = 1; k <= nreq; k++) begin
            idx_c = idw'((32'(last) + k) % nreq);
            if (!found_c && bus.req[idx_c]) begin
                found_c = 1'b1;
                pick_c  = idx_c;
            end
        end
        for (int unsigned i = 0; i < nreq; i++) begin
            if (pick_c == idw'(i)) begin
                sel_a_c = bus.a_in[i*size +: size];
                sel_b_c = bus.b_in[i*size +: size];
                sel_c_c = bus.c_in[i];
            end
        end
    end

    // Sequencer: IDLE grants and latches, CALC adds, HOLD waits for handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            last          <= idw'(nreq - 1);
            win_id        <= '0;
            op_a          <= '0;
            op_b          <= '0;
            op_c          <= 1'b0;
            bus.gnt       <= '0;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_sum   <= '0;
            bus.res_cout  <= 1'b0;
            bus.res_id    <= '0;
            bus.op_cnt    <= '0;
        end else begin
            bus.gnt <= '0;
            case (state)
                IDLE: begin
                    if (found_c) begin
                        bus.gnt  <= nreq'(1) << pick_c;
                        op_a     <= sel_a_c;
                        op_b     <= sel_b_c;
                        op_c     <= sel_c_c;
                        win_id   <= pick_c;
                        last     <= pick_c;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    {bus.res_cout, bus.res_sum} <= sw'(op_a) + sw'(op_b) + sw'(op_c);
                    bus.res_id    <= win_id;
                    bus.res_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.res_valid && bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.op_cnt    <= bus.op_cnt + 16'd1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.busy      <= 1'b0;
                    bus.res_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_adder_arbiter;
    logic clk;
    logic rst_n;

    adder_arbiter_if #(.size(8), .nreq(4), .idw(2)) bus ();

    adder_arbiter #(.size(8), .nreq(4), .idw(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] a_m [4];
    logic [7:0] b_m [4];
    logic       c_m [4];
    logic [3:0] req_drv;
    int         m_last;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < 4; i++) begin
            bus.a_in[i*8 +: 8] = a_m[i];
            bus.b_in[i*8 +: 8] = b_m[i];
            bus.c_in[i]        = c_m[i];
        end
    endtask

    task automatic scramble_ops();
        for (int i = 0; i < 4; i++) begin
            a_m[i] = 8'($urandom);
            b_m[i] = 8'($urandom);
            c_m[i] = 1'($urandom);
        end
        drive_ops();
    endtask

    // Round-robin rule: scan requesters after the previous winner, wrapping
    function automatic int rr_pick(input logic [3:0] r, input int prev);
        int order [$];
        for (int k = 1; k <= 4; k++) order.push_back((prev + k) % 4);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    // One full transaction: grant, result, optional stall, handshake.
    // next_req is applied during CALC together with fresh operands, which the
    // arbiter must ignore until it is back in IDLE.
    task automatic txn(input logic [3:0] next_req, input int stall);
        int         w;
        int         total;
        logic [7:0] e_sum;
        logic       e_cout;
        w      = rr_pick(req_drv, m_last);
        m_last = w;
        total  = int'(a_m[w]) + int'(b_m[w]) + int'(c_m[w]);
        e_sum  = 8'(total % 256);
        e_cout = (total >= 256);

        @(posedge clk); #1;
        check("gnt", 32'(bus.gnt), 32'(1) << w);
        check("busy_calc", 32'(bus.busy), 32'd1);
        check("valid_calc", 32'(bus.res_valid), 32'd0);

        req_drv = next_req;
        bus.req = next_req;
        scramble_ops();

        @(posedge clk); #1;
        check("valid", 32'(bus.res_valid), 32'd1);
        check("sum", 32'(bus.res_sum), 32'(e_sum));
        check("cout", 32'(bus.res_cout), 32'(e_cout));
        check("id", 32'(bus.res_id), 32'(w));
        check("gnt_off", 32'(bus.gnt), 32'd0);

        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_sum", 32'(bus.res_sum), 32'(e_sum));
            check("hold_id", 32'(bus.res_id), 32'(w));
            check("hold_gnt", 32'(bus.gnt), 32'd0);
            check("hold_busy", 32'(bus.busy), 32'd1);
        end

        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        m_cnt++;
        check("done_valid", 32'(bus.res_valid), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_gnt", 32'(bus.gnt), 32'd0);
        check("op_cnt", 32'(bus.op_cnt), 32'(m_cnt % 65536));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.res_ready = 1'b0;
        req_drv       = '0;
        m_last        = 3;
        m_cnt         = 0;
        for (int i = 0; i < 4; i++) begin
            a_m[i] = '0;
            b_m[i] = '0;
            c_m[i] = 1'b0;
        end
        drive_ops();

        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_sum", 32'(bus.res_sum), 32'd0);
        check("rst_cout", 32'(bus.res_cout), 32'd0);
        check("rst_id", 32'(bus.res_id), 32'd0);
        check("rst_op_cnt", 32'(bus.op_cnt), 32'd0);
        rst_n = 1'b1;

        // Single request: 23 + 35 + 1 = 59
        a_m[0] = 8'd23; b_m[0] = 8'd35; c_m[0] = 1'b1;
        drive_ops();
        req_drv = 4'b0001; bus.req = req_drv;
        txn(4'b0000, 0);

        // Carry-out: 255 + 255 + 1
        a_m[2] = 8'hff; b_m[2] = 8'hff; c_m[2] = 1'b1;
        drive_ops();
        req_drv = 4'b0100; bus.req = req_drv;
        txn(4'b0000, 0);

        // Reset while in CALC abandons the transaction
        req_drv = 4'b0010; bus.req = req_drv;
        @(posedge clk); #1;
        check("mid_gnt", 32'(bus.gnt), 32'(1) << rr_pick(req_drv, m_last));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_op_cnt", 32'(bus.op_cnt), 32'd0);
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        rst_n  = 1'b1;
        m_last = 3;
        m_cnt  = 0;

        // Fairness with all requesters continuously high: ids 0,1,2,3,0
        scramble_ops();
        req_drv = 4'b1111; bus.req = req_drv;
        for (int t = 0; t < 5; t++) begin
            check("rr_order", 32'(rr_pick(req_drv, m_last)), 32'(t % 4));
            txn(4'b1111, 0);
        end

        // Backpressure: five stalled cycles before acceptance
        req_drv = 4'b0010; bus.req = req_drv;
        txn(4'b0000, 5);

        // Requester 1 drops before its grant while requester 3 keeps asking
        req_drv = 4'b0001; bus.req = req_drv;
        txn(4'b1010, 0);
        req_drv = 4'b1000; bus.req = req_drv;
        txn(4'b0000, 0);

        // Randomized transactions
        req_drv = 4'($urandom_range(1, 15)); bus.req = req_drv;
        for (int t = 0; t < 25; t++) begin
            txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
        end
        bus.req = '0;
        req_drv = '0;

        // Idle with no requests: no grant, not busy
        repeat (3) @(posedge clk);
        #1;
        check("idle_gnt", 32'(bus.gnt), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Round-robin arbiter and sequencer that shares one parameterized adder between nreq requesters.
- Each requester presents operands a, b and c_in with a request bit.
- The block grants one requester at a time, latches its operands, and computes {cout, sum} = a + b + c_in in a registered stage.
- It holds the result with a valid/ready handshake, tagged with the winner's index.
- It sits between multiple datapath clients and the shared adder resource.

Parameters:
- size, 8, operand/sum width in bits
- nreq, 4, number of requesters (2..8)
- idw, 2, requester-index width; must satisfy 2**idw >= nreq

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req  input  nreq  request bit per requester; held high until that requester's gnt pulse
- a_in  input  nreq*size  packed operand A; requester i occupies [i*size +: size]
- b_in  input  nreq*size  packed operand B, same packing
- c_in  input  nreq  carry-in per requester
- gnt  output  nreq  one-hot grant, one-cycle pulse
- busy  output  1  high whenever state != IDLE
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_sum  output  size  registered sum
- res_cout  output  1  registered carry-out
- res_id  output  idw  index of the requester that owns the result
- op_cnt  output  16  completed-transaction counter; wraps at 65535 -> 0

Behaviour:
- Reset: clock and reset are fixed as stated: one clock; reset synchronous, active-low.
  - When rst_n is sampled low on a rising clk edge: state = IDLE; gnt = 0, busy = 0, res_valid = 0, res_sum = 0, res_cout = 0, res_id = 0, op_cnt = 0.
  - Round-robin pointer last = nreq-1, so requester 0 has highest priority first.
  - Reset mid-operation abandons the transaction; no result is produced.
- States: IDLE, CALC, HOLD.
- IDLE:
  - If req != 0, select the winner: the first set bit of req searching last+1, last+2, ... modulo nreq.
  - On that edge: gnt <= onehot(winner) for exactly one cycle; latch operands a, b, c_in and winner index; last <= winner; state -> CALC.
  - If req == 0, remain in IDLE; gnt = 0.
- CALC (one cycle):
  - {res_cout, res_sum} <= latched a + latched b + latched c_in, computed at size+1 bits with no truncation of the carry.
  - res_id <= winner; res_valid <= 1; state -> HOLD.
  - gnt returns to 0.
- HOLD:
  - res_valid, res_sum, res_cout and res_id stay stable until res_ready is sampled high.
  - On res_valid && res_ready: res_valid <= 0; op_cnt <= op_cnt + 1; state -> IDLE.
  - res_ready is ignored when res_valid = 0.
- Latency:
  - Request sampled in IDLE -> gnt at edge 1 -> res_valid at edge 2.
  - Minimum transaction period is 3 cycles, with res_ready tied high.
- Request sampling:
  - req is sampled only in IDLE. req changes during CALC or HOLD have no effect.
  - A requester dropping req before its grant is simply not served.
  - Operand changes after gnt do not affect the result.
- Fairness: with all req bits continuously high, grants rotate 0, 1, 2, ..., nreq-1, 0, ...
- A single active requester is granted repeatedly, once per transaction.
- Simultaneous events: no new grant is issued in the same cycle as the HOLD handshake; IDLE always occupies at least one cycle.
- Overflow: all-ones + all-ones + 1 gives res_sum = all-ones, res_cout = 1.

Test Plan:
- Reset then single request: size=8, req=0001, a0=23, b0=35, c0=1, res_ready=1 -> gnt=0001 at edge 1; res_valid at edge 2 with sum=59, cout=0, id=0; op_cnt=1.
- Carry-out: req=0100, a2=255, b2=255, c2=1 -> sum=255, cout=1, id=2.
- Round robin: all req high continuously, res_ready=1, distinct operands -> res_id sequence 0,1,2,3,0; each sum matches its requester's operands.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid and outputs stable, busy=1, no gnt pulses; res_ready=1 -> handshake, op_cnt increments exactly once.
- Reset mid-operation: assert rst_n=0 during CALC -> next cycle res_valid=0, busy=0, op_cnt=0; req=1111 afterwards -> first grant goes to requester 0.
- Late drop / operand change: req1 drops before grant while req3 is high -> gnt=1000; altering a3 during CALC leaves res_sum equal to the latched operands.
